// File: rtl/scan_loader_pkg.sv
// Shared types and helpers for the configuration scan loader.
package scan_loader_pkg;

    // Loader phase: idle, shifting the routing chain, shifting the CLB chain.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONN = 2'd1,
        ST_CLB  = 2'd2
    } state_t;

    // Number of whole input words needed to cover a chain of 'bits' bits.
    function automatic int words_for(input int bits, input int width);
        return (bits + width - 1) / width;
    endfunction

endpackage

// File: rtl/scan_serializer.sv
// One-word holding shifter. Emits the held word LSB first, one bit per
// shift cycle, and asks for the next word while its last useful bit is
// leaving so that back-to-back words shift with no bubble.
module scan_serializer #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  active,
    input  logic                  chain_last,
    input  logic                  more_words,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  take,
    output logic                  full,
    output logic                  full_next,
    output logic                  bit_next
);

    localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [WORD_WIDTH-1:0] hold_r;
    logic [WORD_WIDTH-1:0] hold_next;
    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_next;
    logic                  full_r;
    logic                  last_useful;

    // Last-useful-bit detect and ready: ready never looks at word_valid.
    always_comb begin
        last_useful = full_r && ((idx_r == IDX_LAST) || chain_last);
        word_ready  = active && more_words && (!full_r || last_useful);
        take        = word_ready && word_valid;
        full        = full_r;
    end

    // Next holding-register contents: load, shift, drain or hold.
    always_comb begin
        hold_next = hold_r;
        idx_next  = idx_r;
        full_next = full_r;
        if (clear) begin
            full_next = 1'b0;
            idx_next  = IDX_ZERO;
        end else if (take) begin
            hold_next = word_in;
            idx_next  = IDX_ZERO;
            full_next = 1'b1;
        end else if (full_r && last_useful) begin
            full_next = 1'b0;
            idx_next  = IDX_ZERO;
        end else if (full_r) begin
            hold_next = hold_r >> 1'b1;
            idx_next  = idx_r + IDX_ONE;
        end else begin
            full_next = 1'b0;
        end
        bit_next = hold_next[0];
    end

    // Holding register, bit index and occupancy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= {WORD_WIDTH{1'b0}};
            idx_r  <= IDX_ZERO;
            full_r <= 1'b0;
        end else begin
            hold_r <= hold_next;
            idx_r  <= idx_next;
            full_r <= full_next;
        end
    end

endmodule

// File: rtl/scan_loader.sv
// Configuration bitstream driver: streams packed words into the routing
// (conn) scan chain, then the CLB scan chain, with optional readback compare.
module scan_loader
    import scan_loader_pkg::*;
#(
    parameter int CONN_CHAIN_LEN = 64,
    parameter int CLB_CHAIN_LEN  = 32,
    parameter int WORD_WIDTH     = 8
) (
    input  logic                  scan_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  verify,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  conn_scan_in,
    output logic                  conn_scan_en,
    input  logic                  conn_scan_out,
    output logic                  clb_scan_in,
    output logic                  clb_scan_en,
    input  logic                  clb_scan_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CCW         = $clog2(CONN_CHAIN_LEN) + 1;
    localparam int LCW         = $clog2(CLB_CHAIN_LEN) + 1;
    localparam int TOTAL_WORDS = words_for(CONN_CHAIN_LEN, WORD_WIDTH)
                               + words_for(CLB_CHAIN_LEN, WORD_WIDTH);
    localparam int WCW         = $clog2(TOTAL_WORDS + 1);

    localparam logic [CCW-1:0] CONN_LAST  = CCW'(CONN_CHAIN_LEN - 1);
    localparam logic [LCW-1:0] CLB_LAST   = LCW'(CLB_CHAIN_LEN - 1);
    localparam logic [WCW-1:0] WORDS_ALL  = WCW'(TOTAL_WORDS);
    localparam logic [CCW-1:0] CONN_ZERO  = CCW'(0);
    localparam logic [LCW-1:0] CLB_ZERO   = LCW'(0);
    localparam logic [WCW-1:0] WORDS_ZERO = WCW'(0);

    state_t         state_r;
    state_t         state_next;
    logic [CCW-1:0] conn_cnt_r;
    logic [LCW-1:0] clb_cnt_r;
    logic [WCW-1:0] words_r;
    logic           verify_r;
    logic           busy_r;
    logic           done_r;
    logic           error_r;
    logic           conn_en_r;
    logic           conn_in_r;
    logic           clb_en_r;
    logic           clb_in_r;

    logic           start_acc;
    logic           in_conn;
    logic           in_clb;
    logic           shifting;
    logic           conn_at_last;
    logic           clb_at_last;
    logic           chain_last;
    logic           more_words;
    logic           mismatch;

    logic           ser_take;
    logic           ser_full;
    logic           ser_full_next;
    logic           ser_bit_next;

    // Phase decode, last-bit detect and readback compare of the bit on the pins.
    always_comb begin
        start_acc    = start && (state_r == ST_IDLE);
        in_conn      = (state_r == ST_CONN);
        in_clb       = (state_r == ST_CLB);
        shifting     = ser_full && (in_conn || in_clb);
        conn_at_last = in_conn && (conn_cnt_r == CONN_LAST);
        clb_at_last  = in_clb && (clb_cnt_r == CLB_LAST);
        chain_last   = conn_at_last || clb_at_last;
        more_words   = (words_r < WORDS_ALL);
        mismatch     = verify_r &&
                       ((conn_en_r && (conn_scan_out != conn_in_r)) ||
                        (clb_en_r && (clb_scan_out != clb_in_r)));
    end

    // Next phase: a chain ends on the edge that shifts its final bit.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next = ST_CONN;
                else       state_next = ST_IDLE;
            end
            ST_CONN: begin
                if (shifting && conn_at_last) state_next = ST_CLB;
                else                          state_next = ST_CONN;
            end
            ST_CLB: begin
                if (shifting && clb_at_last) state_next = ST_IDLE;
                else                         state_next = ST_CLB;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    scan_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_ser (
        .clk        (scan_clk),
        .rst_n      (rst_n),
        .clear      (start_acc),
        .active     (in_conn || in_clb),
        .chain_last (chain_last),
        .more_words (more_words),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .take       (ser_take),
        .full       (ser_full),
        .full_next  (ser_full_next),
        .bit_next   (ser_bit_next)
    );

    // Phase register.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next;
    end

    // Per-chain bit counters and accepted-word count for the current load.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            conn_cnt_r <= CONN_ZERO;
            clb_cnt_r  <= CLB_ZERO;
            words_r    <= WORDS_ZERO;
        end else if (start_acc) begin
            conn_cnt_r <= CONN_ZERO;
            clb_cnt_r  <= CLB_ZERO;
            words_r    <= WORDS_ZERO;
        end else begin
            if (shifting && in_conn) conn_cnt_r <= conn_cnt_r + CCW'(1);
            if (shifting && in_clb)  clb_cnt_r  <= clb_cnt_r + LCW'(1);
            if (ser_take)            words_r    <= words_r + WCW'(1);
        end
    end

    // Status flags: verify latched with start, done and sticky error.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            busy_r <= (state_next != ST_IDLE);
            if (start_acc) begin
                verify_r <= verify;
                done_r   <= 1'b0;
                error_r  <= 1'b0;
            end else begin
                if (shifting && clb_at_last) done_r  <= 1'b1;
                if (mismatch)                error_r <= 1'b1;
            end
        end
    end

    // Scan pins registered from the shifter's next contents; idle chain stays at 0.
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            conn_en_r <= 1'b0;
            conn_in_r <= 1'b0;
            clb_en_r  <= 1'b0;
            clb_in_r  <= 1'b0;
        end else begin
            conn_en_r <= ser_full_next && (state_next == ST_CONN);
            conn_in_r <= ser_full_next && (state_next == ST_CONN) && ser_bit_next;
            clb_en_r  <= ser_full_next && (state_next == ST_CLB);
            clb_in_r  <= ser_full_next && (state_next == ST_CLB) && ser_bit_next;
        end
    end

    assign conn_scan_en = conn_en_r;
    assign conn_scan_in = conn_in_r;
    assign clb_scan_en  = clb_en_r;
    assign clb_scan_in  = clb_in_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader with 10/6/8 chains: models both fabric chains as
// plain shift registers and checks every load against the word stream.
module tb_scan_loader;

    localparam int CL  = 10;
    localparam int BL  = 6;
    localparam int W   = 8;
    localparam int NCW = (CL + W - 1) / W;
    localparam int NBW = (BL + W - 1) / W;
    localparam int NW  = NCW + NBW;

    logic         scan_clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         verify;
    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;
    logic         conn_scan_in;
    logic         conn_scan_en;
    logic         conn_scan_out;
    logic         clb_scan_in;
    logic         clb_scan_en;
    logic         clb_scan_out;
    logic         busy;
    logic         done;
    logic         error;

    logic [CL-1:0] conn_chain = '0;
    logic [BL-1:0] clb_chain  = '0;
    logic [CL-1:0] snap_conn;
    logic [BL-1:0] snap_clb;

    logic [W-1:0] ld_words [NW];
    int           ld_dly   [NW];

    int n_cmp = 0;
    int n_bad = 0;

    scan_loader #(
        .CONN_CHAIN_LEN (CL),
        .CLB_CHAIN_LEN  (BL),
        .WORD_WIDTH     (W)
    ) dut (
        .scan_clk      (scan_clk),
        .rst_n         (rst_n),
        .start         (start),
        .verify        (verify),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .conn_scan_in  (conn_scan_in),
        .conn_scan_en  (conn_scan_en),
        .conn_scan_out (conn_scan_out),
        .clb_scan_in   (clb_scan_in),
        .clb_scan_en   (clb_scan_en),
        .clb_scan_out  (clb_scan_out),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 scan_clk = ~scan_clk;

    // Fabric chains: shift toward the tail when enabled.
    always @(posedge scan_clk) begin
        if (conn_scan_en === 1'b1) conn_chain <= {conn_chain[CL-2:0], conn_scan_in};
        if (clb_scan_en === 1'b1)  clb_chain  <= {clb_chain[BL-2:0], clb_scan_in};
    end
    assign conn_scan_out = conn_chain[CL-1];
    assign clb_scan_out  = clb_chain[BL-1];

    // Bit k of the load stream: conn bits first, CLB bits start on a fresh word.
    function automatic logic stream_bit(input int k);
        logic [W-1:0] w;
        int j;
        if (k < CL) begin
            w = ld_words[k / W];
            j = k % W;
        end else begin
            w = ld_words[NCW + (k - CL) / W];
            j = (k - CL) % W;
        end
        return w[j];
    endfunction

    task automatic set_words(input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2, input int d0, input int d1, input int d2);
        ld_words[0] = w0; ld_words[1] = w1; ld_words[2] = w2;
        ld_dly[0] = d0;   ld_dly[1] = d1;   ld_dly[2] = d2;
    endtask

    // Runs one load; busy_pulse_cyc>0 pulses start mid-load, abort_after>0 resets after that many conn bits.
    task automatic run_load(input string name, input bit ver, input int busy_pulse_cyc, input int abort_after);
        int   cyc, wi, waitc, nconn, nclb, shifts, first_bad, first_sh, last_sh, dsum, dmid;
        bit   got_done;
        logic exp_err;
        logic old_b;
        snap_conn = conn_chain;
        snap_clb  = clb_chain;
        first_bad = -1;
        for (int k = 0; k < CL + BL; k++) begin
            old_b = (k < CL) ? snap_conn[CL-1-k] : snap_clb[BL-1-(k-CL)];
            if (first_bad < 0 && old_b !== stream_bit(k)) first_bad = k;
        end
        dsum = 0;
        for (int i = 0; i < NW; i++) dsum += ld_dly[i];
        dmid = dsum - ld_dly[0];

        @(negedge scan_clk);
        start = 1'b1; verify = ver; word_valid = 1'b0;
        @(negedge scan_clk);
        start = 1'b0; verify = 1'($urandom_range(0, 1));
        cyc = 1; wi = 0; waitc = 0; nconn = 0; nclb = 0; shifts = 0;
        got_done = 1'b0; first_sh = -1; last_sh = -1;
        while (cyc < 300) begin
            if (abort_after > 0 && nconn == abort_after) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({conn_scan_en, clb_scan_en, busy, word_ready} !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL %s reset_drop: got en=%b%b busy=%b ready=%b, want all 0",
                             name, conn_scan_en, clb_scan_en, busy, word_ready);
                end
                word_valid = 1'b0; start = 1'b0;
                @(negedge scan_clk);
                rst_n = 1'b1;
                return;
            end
            if (cyc == 1) begin
                n_cmp++;
                if ({busy, word_ready, done, error} !== 4'b1100) begin
                    n_bad++;
                    $display("FAIL %s start_flags: got busy=%b ready=%b done=%b error=%b, want 1 1 0 0",
                             name, busy, word_ready, done, error);
                end
            end
            n_cmp++;
            if (conn_scan_en !== 1'b1 && conn_scan_en !== 1'b0 || clb_scan_en !== 1'b1 && clb_scan_en !== 1'b0
                || (conn_scan_en === 1'b1 && clb_scan_en === 1'b1)) begin
                n_bad++;
                $display("FAIL %s enables cyc%0d: got conn_en=%b clb_en=%b, want exclusive",
                         name, cyc, conn_scan_en, clb_scan_en);
            end
            exp_err = ver && (first_bad >= 0) && (shifts > first_bad);
            n_cmp++;
            if (error !== exp_err) begin
                n_bad++;
                $display("FAIL %s error cyc%0d: got %b, want %b", name, cyc, error, exp_err);
            end
            if (conn_scan_en === 1'b1) begin
                n_cmp++;
                if (nconn >= CL || conn_scan_in !== stream_bit(nconn) || clb_scan_in !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s conn_bit%0d: got in=%b clb_in=%b, want %b 0",
                             name, nconn, conn_scan_in, clb_scan_in, (nconn < CL) ? stream_bit(nconn) : 1'bx);
                end
                nconn++;
            end else if (clb_scan_en === 1'b1) begin
                n_cmp++;
                if (nconn != CL || nclb >= BL || clb_scan_in !== stream_bit(CL + nclb) || conn_scan_in !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s clb_bit%0d: got in=%b conn_in=%b after %0d conn bits, want %b 0 after %0d",
                             name, nclb, clb_scan_in, conn_scan_in, nconn,
                             (nclb < BL) ? stream_bit(CL + nclb) : 1'bx, CL);
                end
                nclb++;
            end
            if (conn_scan_en === 1'b1 || clb_scan_en === 1'b1) begin
                shifts++;
                if (first_sh < 0) first_sh = cyc;
                last_sh = cyc;
            end
            if (wi == NW) begin
                n_cmp++;
                if (word_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s ready_after_last_word cyc%0d: got %b, want 0", name, cyc, word_ready);
                end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            start = (cyc == busy_pulse_cyc);
            if (cyc == busy_pulse_cyc) verify = 1'b1;
            if (wi < NW && word_ready === 1'b1) begin
                if (waitc < ld_dly[wi]) begin
                    word_valid = 1'b0;
                    waitc++;
                end else begin
                    word_valid = 1'b1;
                    word_in    = ld_words[wi];
                    wi++;
                    waitc = 0;
                end
            end else begin
                word_valid = 1'($urandom_range(0, 1));
                word_in    = 8'($urandom);
            end
            @(negedge scan_clk);
            cyc++;
        end
        word_valid = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (!got_done) begin
            n_bad++;
            $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
        end else begin
            if (cyc - 1 != CL + BL + 1 + dsum) begin
                n_bad++;
                $display("FAIL %s latency: got %0d edges to done, want %0d", name, cyc - 1, CL + BL + 1 + dsum);
            end
            n_cmp++;
            if (nconn != CL || nclb != BL) begin
                n_bad++;
                $display("FAIL %s bit_count: got %0d/%0d, want %0d/%0d", name, nconn, nclb, CL, BL);
            end
            n_cmp++;
            if (last_sh - first_sh + 1 - (CL + BL) != dmid) begin
                n_bad++;
                $display("FAIL %s stall_gaps: got %0d idle cycles, want %0d",
                         name, last_sh - first_sh + 1 - (CL + BL), dmid);
            end
            n_cmp++;
            if (busy !== 1'b0 || error !== exp_err) begin
                n_bad++;
                $display("FAIL %s end_flags: got busy=%b error=%b, want 0 %b", name, busy, error, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge scan_clk);
        n_cmp++;
        if ({word_ready, conn_scan_in, conn_scan_en, clb_scan_in, clb_scan_en, busy, done, error} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_values: got %b, want 00000000",
                     {word_ready, conn_scan_in, conn_scan_en, clb_scan_in, clb_scan_en, busy, done, error});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_valid(input logic exp_error);
        logic [CL-1:0] c0;
        logic [BL-1:0] b0;
        c0 = conn_chain;
        b0 = clb_chain;
        for (int i = 0; i < 5; i++) begin
            @(negedge scan_clk);
            n_cmp++;
            if ({word_ready, conn_scan_en, clb_scan_en, busy, done, error} !== {5'b00001, exp_error}) begin
                n_bad++;
                $display("FAIL idle_valid: got ready=%b en=%b%b busy=%b done=%b error=%b, want 0 00 0 1 %b",
                         word_ready, conn_scan_en, clb_scan_en, busy, done, error, exp_error);
            end
            word_valid = 1'b1;
            word_in    = 8'($urandom);
        end
        @(negedge scan_clk);
        word_valid = 1'b0;
        n_cmp++;
        if (conn_chain !== c0 || clb_chain !== b0) begin
            n_bad++;
            $display("FAIL idle_no_shift: got chains %h/%h, want %h/%h", conn_chain, clb_chain, c0, b0);
        end
    endtask

    task automatic test_random(input int loads);
        bit ver;
        for (int n = 0; n < loads; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < NW; i++) ld_words[i] = 8'($urandom);
            end
            for (int i = 0; i < NW; i++) ld_dly[i] = $urandom_range(0, 3);
            ver = 1'($urandom_range(0, 1));
            run_load("random", ver, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : 0, 0);
        end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; verify = 1'b0; word_in = '0; word_valid = 1'b0;
        #2 rst_n = 1'b0;
        test_reset();

        set_words(8'hA5, 8'h03, 8'h3C, 0, 0, 0);
        run_load("basic", 1'b0, 0, 0);
        set_words(8'hA5, 8'h03, 8'h3C, 0, 3, 0);
        run_load("stall", 1'b0, 0, 0);
        set_words(8'hA5, 8'h03, 8'h3C, 0, 0, 0);
        run_load("verify_ok", 1'b1, 0, 0);
        set_words(8'hA4, 8'h03, 8'h3C, 0, 0, 0);
        run_load("verify_bad", 1'b1, 0, 0);
        test_idle_valid(1'b1);
        set_words(8'hA5, 8'h03, 8'h3C, 1, 0, 2);
        run_load("busy_start", 1'b0, 6, 0);
        set_words(8'h5A, 8'hC2, 8'h17, 0, 0, 0);
        run_load("reset_mid", 1'b0, 0, 5);
        run_load("reload", 1'b0, 0, 0);
        run_load("reload_verify", 1'b1, 0, 0);
        test_random(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
